// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// FSM states, opcodes, ALUOp/ALUSrcB/PCSource and the control bundle.
package mips_ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ADDI_WB  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational state -> control vector decode; only FETCH
// looks at mem_ready, to gate the IR/PC load.
module main_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequencing,
// opcode dispatch, retired-instruction count and illegal-op flag.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_retired,
  output logic             illegal_op
);

  logic [3:0]       state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ill_q, ill_d;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d = S_IDLE;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_RTYPE: state_d = S_EXEC_R;
          opcode == OP_LW,
          opcode == OP_SW:    state_d = S_MEM_ADDR;
          opcode == OP_BEQ:   state_d = S_BRANCH;
          opcode == OP_J:     state_d = S_JUMP;
          opcode == OP_ADDI:  state_d = S_ADDI_EX;
          default: begin
            state_d = S_FETCH;
            ill_d   = 1'b1;
          end
        endcase
      end
      // op_q was captured in DECODE; only lw/sw can reach here
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  assign retire = (state_q == S_MEM_WB)
                | ((state_q == S_MEM_WR) & mem_ready)
                | (state_q == S_R_WB)
                | (state_q == S_BRANCH)
                | (state_q == S_JUMP)
                | (state_q == S_ADDI_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  main_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign PCWrite       = ctrl.pc_write;
  assign PCWriteCond   = ctrl.pc_write_cond;
  assign IorD          = ctrl.iord;
  assign MemRead       = ctrl.mem_read;
  assign MemWrite      = ctrl.mem_write;
  assign IRWrite       = ctrl.ir_write;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign RegDst        = ctrl.reg_dst;
  assign RegWrite      = ctrl.reg_write;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign ALUOp         = ctrl.alu_op;
  assign PCSource      = ctrl.pc_source;
  assign state_o       = state_q;
  assign instr_retired = cnt_q;
  assign illegal_op    = ill_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Instruction-level model expands each instruction into its expected
// per-cycle state/control trace; a monitor checks both DUT widths.
module tb_multicycle_main_control;

  localparam int IDLE = 0, FETCH = 1, DEC = 2, MADDR = 3, MRD = 4;
  localparam int MWB = 5, MWR = 6, EXR = 7, RWB = 8, BR = 9;
  localparam int JMP = 10, AEX = 11, AWB = 12;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, ADDI = 6'b001000;

  typedef struct {
    bit         rst;
    logic [5:0] op;
    bit         mr;
  } stim_t;

  typedef struct {
    int          st;
    logic [15:0] ctrl;
    bit          ill;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;

  logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
  logic [1:0] sb, aop, pcs;
  logic [3:0] st;
  logic [31:0] cnt;
  logic ill;

  logic pcw4, pcwc4, iord4, mrd4, mwr4, irw4, m2r4, rdst4, rw4, sa4;
  logic [1:0] sb4, aop4, pcs4;
  logic [3:0] st4;
  logic [3:0] cnt4;
  logic ill4;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  logic [31:0] mcnt = 0;
  bit pend = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd),
    .MemWrite(mwr), .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst),
    .RegWrite(rw), .ALUSrcA(sa), .ALUSrcB(sb), .ALUOp(aop),
    .PCSource(pcs), .state_o(st), .instr_retired(cnt),
    .illegal_op(ill)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw4), .PCWriteCond(pcwc4), .IorD(iord4), .MemRead(mrd4),
    .MemWrite(mwr4), .IRWrite(irw4), .MemtoReg(m2r4), .RegDst(rdst4),
    .RegWrite(rw4), .ALUSrcA(sa4), .ALUSrcB(sb4), .ALUOp(aop4),
    .PCSource(pcs4), .state_o(st4), .instr_retired(cnt4),
    .illegal_op(ill4)
  );

  function automatic bit legal(logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ ||
           op == J || op == ADDI;
  endfunction

  // order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  //        MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource
  function automatic logic [15:0] want_ctrl(int s, bit m);
    logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw;
    logic a_m2r, a_rdst, a_rw, a_sa;
    logic [1:0] a_sb, a_aop, a_pcs;
    {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw} = '0;
    {a_m2r, a_rdst, a_rw, a_sa, a_sb, a_aop, a_pcs} = '0;
    case (s)
      FETCH: begin a_mrd = 1; a_sb = 2'b01; a_irw = m; a_pcw = m; end
      DEC:   a_sb = 2'b11;
      MADDR: begin a_sa = 1; a_sb = 2'b10; end
      MRD:   begin a_mrd = 1; a_iord = 1; end
      MWB:   begin a_rw = 1; a_m2r = 1; end
      MWR:   begin a_mwr = 1; a_iord = 1; end
      EXR:   begin a_sa = 1; a_aop = 2'b10; end
      RWB:   begin a_rw = 1; a_rdst = 1; end
      BR: begin
        a_sa = 1; a_aop = 2'b01; a_pcwc = 1; a_pcs = 2'b01;
      end
      JMP:   begin a_pcw = 1; a_pcs = 2'b10; end
      AEX:   begin a_sa = 1; a_sb = 2'b10; end
      AWB:   a_rw = 1;
      default: ;
    endcase
    return {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw,
            a_m2r, a_rdst, a_rw, a_sa, a_sb, a_aop, a_pcs};
  endfunction

  task automatic do_reset(int n);
    stim_t s;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      s.rst = 0; s.op = 6'($urandom); s.mr = 1'($urandom);
      stim_q.push_back(s);
      e.st = IDLE; e.ctrl = '0; e.ill = 0; e.cnt = 0;
      exp_q.push_back(e);
    end
    mcnt = 0;
    pend = 0;
    s.rst = 1; s.op = 6'($urandom); s.mr = 1'($urandom);
    stim_q.push_back(s);
    e.st = IDLE; e.ctrl = '0; e.ill = 0; e.cnt = 0;
    exp_q.push_back(e);
  endtask

  // Expand one instruction: wf/wm = wait cycles in fetch/memory,
  // abort_at >= 0 cuts the trace after that many cycles and resets.
  task automatic instr(logic [5:0] op, int wf, int wm, int abort_at);
    int sts[$];
    bit mrs[$];
    int len;
    stim_t s;
    exp_t e;
    for (int i = 0; i < wf; i++) begin
      sts.push_back(FETCH); mrs.push_back(0);
    end
    sts.push_back(FETCH); mrs.push_back(1);
    sts.push_back(DEC); mrs.push_back(1'($urandom));
    if (op == LW) begin
      sts.push_back(MADDR); mrs.push_back(1'($urandom));
      for (int i = 0; i < wm; i++) begin
        sts.push_back(MRD); mrs.push_back(0);
      end
      sts.push_back(MRD); mrs.push_back(1);
      sts.push_back(MWB); mrs.push_back(1'($urandom));
    end else if (op == SW) begin
      sts.push_back(MADDR); mrs.push_back(1'($urandom));
      for (int i = 0; i < wm; i++) begin
        sts.push_back(MWR); mrs.push_back(0);
      end
      sts.push_back(MWR); mrs.push_back(1);
    end else if (op == RT) begin
      sts.push_back(EXR); mrs.push_back(1'($urandom));
      sts.push_back(RWB); mrs.push_back(1'($urandom));
    end else if (op == BEQ) begin
      sts.push_back(BR); mrs.push_back(1'($urandom));
    end else if (op == J) begin
      sts.push_back(JMP); mrs.push_back(1'($urandom));
    end else if (op == ADDI) begin
      sts.push_back(AEX); mrs.push_back(1'($urandom));
      sts.push_back(AWB); mrs.push_back(1'($urandom));
    end
    len = sts.size();
    if (abort_at >= 0 && abort_at < len) len = abort_at;
    for (int i = 0; i < len; i++) begin
      s.rst = 1;
      s.op = (sts[i] == DEC) ? op : 6'($urandom);
      s.mr = mrs[i];
      stim_q.push_back(s);
      e.st = sts[i];
      e.ctrl = want_ctrl(sts[i], mrs[i]);
      e.ill = pend;
      e.cnt = mcnt;
      exp_q.push_back(e);
      pend = (sts[i] == DEC) && !legal(op);
    end
    if (len < sts.size()) do_reset(1);
    else if (legal(op)) mcnt = mcnt + 1;
  endtask

  task automatic chk(string nm, int cyc, logic [31:0] got,
                     logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc%0d got %0h want %0h", nm, cyc, got, want);
    end
  endtask

  initial begin
    logic [5:0] op;
    int k, len;
    do_reset(3);
    instr(LW, 0, 0, -1);
    instr(SW, 0, 3, -1);
    instr(RT, 0, 0, -1);
    instr(BEQ, 0, 0, -1);
    instr(6'b111111, 0, 0, -1);
    instr(LW, 0, 1, 4);
    do_reset(2);
    for (int i = 0; i < 17; i++) instr(J, 0, 0, -1);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = J;
        5: op = ADDI;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : -1;
      instr(op, $urandom_range(0, 2), $urandom_range(0, 2), len);
    end

    fork
      begin
        foreach (stim_q[i]) begin
          @(negedge clk);
          rst_n = stim_q[i].rst;
          opcode = stim_q[i].op;
          mem_ready = stim_q[i].mr;
        end
      end
      begin
        foreach (exp_q[i]) begin
          @(negedge clk);
          #2;
          chk("state", i, {st4, st}, {4'(exp_q[i].st), 4'(exp_q[i].st)});
          chk("ctrl", i,
              {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa,
               sb, aop, pcs},
              exp_q[i].ctrl);
          chk("ctrl_w4", i,
              {pcw4, pcwc4, iord4, mrd4, mwr4, irw4, m2r4, rdst4, rw4,
               sa4, sb4, aop4, pcs4},
              exp_q[i].ctrl);
          chk("illegal_op", i, {ill4, ill}, {exp_q[i].ill, exp_q[i].ill});
          chk("retired", i, cnt, exp_q[i].cnt);
          chk("retired_w4", i, cnt4, exp_q[i].cnt[3:0]);
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
